// File: rtl/gelu_pwl_stage.sv
// Piecewise-linear GELU over an MLP_DIM vector, LANES elements per cycle.
// x is captured on start && valid_in; y fills progressively; done pulses once.
module gelu_pwl_stage #(
  parameter int MLP_DIM    = 64,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] x [MLP_DIM],
  output logic                  valid_out,
  output logic                  done,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] y [MLP_DIM]
);

  localparam int IW = (MLP_DIM > 1) ? $clog2(MLP_DIM) : 1;
  localparam logic [IW-1:0] STEP = IW'(LANES);
  localparam logic [IW-1:0] LAST = IW'(MLP_DIM - LANES);
  localparam logic signed [DATA_WIDTH-1:0] NEG_HALF =
    {2'b11, {(DATA_WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] buf_q [MLP_DIM];
  logic [DATA_WIDTH-1:0] buf_d [MLP_DIM];
  logic [DATA_WIDTH-1:0] y_q   [MLP_DIM];
  logic [DATA_WIDTH-1:0] y_d   [MLP_DIM];
  logic                  accept;

  // Shift by 3 on [-0.5, 0) cannot overflow; everything below clamps to 0.
  function automatic logic [DATA_WIDTH-1:0] act(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if (!v[DATA_WIDTH-1]) return v;
    if (v >= NEG_HALF) return v >>> 3;
    return '0;
  endfunction

  assign accept = (state_q == IDLE) && start && valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (idx_q == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    valid_out = 1'b0;
    unique case (state_q)
      IDLE: ;
      RUN:  busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        valid_out = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    buf_d = buf_q;
    y_d   = y_q;
    if (accept) begin
      buf_d = x;
      idx_d = '0;
    end else if (state_q == RUN) begin
      idx_d = idx_q + STEP;
      for (int i = 0; i < MLP_DIM; i++) begin
        if (i >= int'(idx_q) && i < int'(idx_q) + LANES) begin
          y_d[i] = act(buf_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      buf_q <= '{default: '0};
      y_q   <= '{default: '0};
    end else begin
      idx_q <= idx_d;
      buf_q <= buf_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_gelu_pwl_stage.sv
// Scoreboard bench for gelu_pwl_stage: stimulus queues expected y and done
// cycle; a negedge monitor pops and compares on every valid_out.
module tb_gelu_pwl_stage;

  localparam int N  = 64;
  localparam int DW = 16;
  localparam int L  = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t y;
    int   cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          start;
  logic          valid_in;
  logic [DW-1:0] x [N];
  logic          valid_out;
  logic          done;
  logic          busy;
  logic [DW-1:0] y [N];

  int   n_chk;
  int   n_fail;
  int   ecnt;
  int   base;
  exp_t sb [$];
  vec_t last_y;

  logic [DW-1:0] xa [8] = '{16'h7FFF, 16'h0000, 16'hE000, 16'hC000,
                            16'hBFFF, 16'h8000, 16'hFFF8, 16'hFFF9};
  logic [DW-1:0] ya [8] = '{16'h7FFF, 16'h0000, 16'hFC00, 16'hF800,
                            16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
  logic [DW-1:0] xb [8] = '{16'hC001, 16'hFFFF, 16'h0001, 16'hBFFE,
                            16'h4000, 16'hF000, 16'hC008, 16'h8001};
  logic [DW-1:0] yb [8] = '{16'hF800, 16'hFFFF, 16'h0001, 16'h0000,
                            16'h4000, 16'hFE00, 16'hF801, 16'h0000};

  gelu_pwl_stage #(
    .MLP_DIM   (N),
    .DATA_WIDTH(DW),
    .LANES     (L)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .valid_in (valid_in),
    .x        (x),
    .valid_out(valid_out),
    .done     (done),
    .busy     (busy),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic vec_t fill(input logic [DW-1:0] v);
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = v;
    return r;
  endfunction

  function automatic vec_t get_y();
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = y[i];
    return r;
  endfunction

  task automatic set_x(input vec_t v);
    for (int i = 0; i < N; i++) x[i] = v[i];
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string nm, input vec_t act, input vec_t exp);
    int bad;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      bad = -1;
      for (int i = N - 1; i >= 0; i--) if (act[i] !== exp[i]) bad = i;
      $display("FAIL %s: y[%0d] got %h expected %h",
               nm, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic check_ctl(input string nm, input logic [2:0] exp);
    n_chk++;
    if ({busy, done, valid_out} !== exp) begin
      n_fail++;
      $display("FAIL %s: busy/done/valid_out got %b expected %b",
               nm, {busy, done, valid_out}, exp);
    end
  endtask

  // Drives a request in the current cycle (cycle 0 of the job).
  task automatic issue(input vec_t v, input vec_t e, input bit expect_done);
    exp_t t;
    set_x(v);
    start    = 1'b1;
    valid_in = 1'b1;
    base     = ecnt;
    if (expect_done) begin
      t.y   = e;
      t.cyc = ecnt + 17;
      sb.push_back(t);
    end
  endtask

  always @(negedge clk) begin
    exp_t t;
    if (valid_out || done) begin
      check_int("done_eq_valid_out", int'(done), int'(valid_out));
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done at %0d expected none", ecnt);
      end else begin
        t = sb.pop_front();
        check_int("done_cycle", ecnt, t.cyc);
        check_vec("y_result", get_y(), t.y);
      end
    end
  end

  initial begin
    vec_t v;
    vec_t e;
    exp_t t;
    n_chk    = 0;
    n_fail   = 0;
    base     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    valid_in = 1'b0;
    set_x(fill('0));

    repeat (3) begin
      @(negedge clk);
      check_ctl("reset_ctl", 3'b000);
    end
    rst = 1'b0;
    check_vec("reset_y", get_y(), fill('0));
    @(negedge clk);
    check_ctl("post_reset_ctl", 3'b000);

    // all 0x2000: busy over cycles 1..17, done at 17
    @(negedge clk);
    issue(fill(16'h2000), fill(16'h2000), 1'b1);
    check_ctl("t1_cycle0", 3'b000);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start    = 1'b0;
        valid_in = 1'b0;
      end
      check_int("t1_busy", int'(busy), (k <= 17) ? 1 : 0);
    end

    // region boundaries
    for (int i = 0; i < N; i++) begin
      v[i] = xa[i % 8];
      e[i] = ya[i % 8];
    end
    @(negedge clk);
    issue(v, e, 1'b1);
    repeat (19) begin
      @(negedge clk);
      start    = 1'b0;
      valid_in = 1'b0;
    end

    for (int i = 0; i < N; i++) begin
      v[i] = xb[i % 8];
      e[i] = yb[i % 8];
    end
    @(negedge clk);
    issue(v, e, 1'b1);
    repeat (19) begin
      @(negedge clk);
      start    = 1'b0;
      valid_in = 1'b0;
    end

    // x overwritten after capture, stray request at cycle 5
    for (int i = 0; i < N; i++) begin
      v[i] = (i % 2 == 0) ? 16'h0400 : 16'hF000;
      e[i] = (i % 2 == 0) ? 16'h0400 : 16'hFE00;
    end
    last_y = e;
    @(negedge clk);
    issue(v, e, 1'b1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start    = 1'b0;
        valid_in = 1'b0;
        set_x(fill(16'h1234));
      end
      if (k == 5) begin
        start    = 1'b1;
        valid_in = 1'b1;
      end
      if (k == 6) begin
        start    = 1'b0;
        valid_in = 1'b0;
      end
    end

    // start without valid_in, then valid_in without start
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      check_ctl("t4_start_only", 3'b000);
    end
    start    = 1'b0;
    valid_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_ctl("t4_valid_only", 3'b000);
    end
    valid_in = 1'b0;
    check_vec("t4_y_unchanged", get_y(), last_y);

    // reset at cycle 6, then immediate new job
    @(negedge clk);
    issue(fill(16'h3000), fill(16'h3000), 1'b0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start    = 1'b0;
        valid_in = 1'b0;
      end
      if (k == 6) rst = 1'b1;
      if (k == 7) begin
        rst = 1'b0;
        check_vec("t5_y_zero", get_y(), fill('0));
        check_ctl("t5_after_reset", 3'b000);
      end
    end
    issue(fill(16'h1000), fill(16'h1000), 1'b1);
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start    = 1'b0;
        valid_in = 1'b0;
      end
      check_int("t5_busy", int'(busy), (k <= 17) ? 1 : 0);
    end

    // back-to-back with start && valid_in held high
    @(negedge clk);
    issue(fill(16'h0800), fill(16'h0800), 1'b1);
    t.y   = fill(16'h0800);
    t.cyc = base + 35;
    sb.push_back(t);
    t.cyc = base + 53;
    sb.push_back(t);
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      if (k == 53) begin
        start    = 1'b0;
        valid_in = 1'b0;
      end
      if (k == 18 || k == 36) check_int("t6_idle_gap", int'(busy), 0);
      if (k == 19 || k == 37) check_int("t6_rearm", int'(busy), 1);
    end

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check_int("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gelu_pwl_stage.md
GELU_PWL_STAGE -- requirements
Module: gelu_pwl_stage

Interface
REQ-001 The block SHALL have parameter MLP_DIM, default 64, giving the number of vector elements processed per job.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the element width in signed Q0.15.
REQ-003 The block SHALL have parameter LANES, default 4, giving the number of elements processed per cycle; MLP_DIM SHALL be an integer multiple of LANES.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit wide: the synchronous active-high reset.
REQ-007 Port start SHALL be an input, 1 bit wide: the job request.
REQ-008 Port valid_in SHALL be an input, 1 bit wide: qualifies x.
REQ-009 Port x SHALL be an input array of MLP_DIM elements, each DATA_WIDTH bits: the pre-activation vector, i.e. the FC-layer output with bias added.
REQ-010 Port valid_out SHALL be an output, 1 bit wide: y holds a complete result.
REQ-011 Port done SHALL be an output, 1 bit wide: the job-complete pulse.
REQ-012 Port busy SHALL be an output, 1 bit wide: high while a job is in progress.
REQ-013 Port y SHALL be an output array of MLP_DIM elements, each DATA_WIDTH bits: the activated vector.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE, start && valid_in sampled high SHALL capture all of x into an internal buffer, clear the element index to 0, and move the FSM to RUN.
REQ-016 In IDLE, start without valid_in, or valid_in without start, SHALL cause no action.
REQ-017 In RUN, each cycle SHALL compute elements idx..idx+LANES-1 from the buffer, write them to the y registers, and advance idx by LANES.
REQ-018 RUN SHALL move to DONE on the edge that processes the final lane group, idx = MLP_DIM-LANES.
REQ-019 In DONE, valid_out and done SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-020 busy SHALL be high in RUN and DONE and low in IDLE.
REQ-021 valid_out, done and busy SHALL be decoded from the state register only.
REQ-022 Latency: done SHALL be high exactly MLP_DIM/LANES+1 cycles after the cycle in which start && valid_in was sampled (17 cycles at default parameters).
REQ-023 start and valid_in SHALL be ignored in RUN and DONE, with no queuing; a new request is accepted only in IDLE.
REQ-024 With start and valid_in held high continuously, jobs SHALL be accepted every MLP_DIM/LANES+2 cycles.
REQ-025 Changes on x after the capture edge SHALL NOT affect the job in progress.
REQ-026 y elements MAY update progressively during RUN.
REQ-027 y SHALL be stable from the DONE cycle until the first RUN write of the next job.
REQ-028 Activation, for signed input v with output out, element-wise, purely combinational per lane:
  - v >= 0: out = v
  - -0.5 (0xC000) <= v < 0: out = v arithmetically shifted right by 3, with sign preserved
  - v < 0xC000, including 0x8000: out = 0
REQ-029 The activation arithmetic SHALL be DATA_WIDTH-bit signed throughout, with no overflow possible and no rounding.

Reset
REQ-030 rst sampled high SHALL force the state to IDLE, idx to 0, the buffer to 0, and all y elements to 0.
REQ-031 While reset is applied and after it is released, valid_out, done and busy SHALL be 0.
REQ-032 Reset asserted mid-RUN or in DONE SHALL abort the job with no done pulse and zero y.
REQ-033 In the cycle immediately after reset is released, a start && valid_in request SHALL be accepted normally.

Verification
REQ-034 A bench SHALL cover: all x = 0x2000 with start && valid_in for one cycle (cycle 0) -> done high only at cycle 17, busy high for cycles 1-17, every y = 0x2000.
REQ-035 A bench SHALL cover: x = {0x7FFF, 0x0000, 0xE000, 0xC000, 0xBFFF, 0x8000, 0xFFF8, 0xFFF9, ...} -> y = {0x7FFF, 0x0000, 0xFC00, 0xF800, 0x0000, 0x0000, 0xFFFF, 0xFFFF}.
REQ-036 A bench SHALL cover: x overwritten with 0x1234 one cycle after capture, plus a start pulse at cycle 5 -> y reflects the originally captured x, and exactly one done pulse occurs at cycle 17.
REQ-037 A bench SHALL cover: start held high with valid_in low for 30 cycles -> busy, done and valid_out stay 0, and y is unchanged.
REQ-038 A bench SHALL cover: rst pulsed for one cycle at cycle 6 of a job -> all y are 0 and busy is 0 from the next cycle, done is never asserted, and a new job started immediately completes with done at +17.
REQ-039 A bench SHALL cover: start && valid_in held high continuously -> done pulses at cycles 17, 35 and 53.
